// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential signed multiply/divide controller:
// FSM state encoding, default operand width and exception flag constants.
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_ZERO = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Flag values reported on data_exception for each exceptional outcome
    localparam logic DIV0_EXC     = 1'b1;
    localparam logic DIV_OVF_EXC  = 1'b1;
    localparam logic MULT_OVF_EXC = 1'b1;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
// Combinational, zero latency; no flow control of its own.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               mode_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd};
        acc_next = '0;
        if (mode_div) begin
            // Upper half holds the partial remainder, quotient bits enter at the bottom
            if (diff[WIDTH]) begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide: result pulse WIDTH+1 edges after start (2 for divide-by-zero).
// busy stalls the issuing pipeline; starts arriving while busy are ignored.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [CW-1:0]      count;
    logic               neg;

    logic               accept;
    logic               start_mult;
    logic               start_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_hi;
    logic [WIDTH-1:0]   quot_s;
    logic               mult_ovf;
    logic               div_ovf;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (state == ST_DIV),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_step)
    );

    always_comb begin
        accept     = (state == ST_IDLE) || (state == ST_DONE);
        start_mult = accept && ctrl_MULT;
        start_div  = accept && ctrl_DIV && !ctrl_MULT;
        a_neg      = data_operandA[WIDTH-1];
        b_neg      = data_operandB[WIDTH-1];
        a_mag      = a_neg ? -data_operandA : data_operandA;
        b_mag      = b_neg ? -data_operandB : data_operandB;
        // Fixup terms are only consumed on the final step, when acc_step is complete
        prod_s     = neg ? -acc_step : acc_step;
        prod_hi    = prod_s[2*WIDTH-1:WIDTH-1];
        mult_ovf   = !((&prod_hi) || !(|prod_hi));
        quot_s     = neg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        // Same-sign operands with quotient MSB set only happens for MIN / -1
        div_ovf    = !neg && acc_step[WIDTH-1];
    end

    always_comb begin
        state_nxt      = state;
        data_resultRDY = 1'b0;
        busy           = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                data_resultRDY = (state == ST_DONE);
                if (start_mult) begin
                    state_nxt = ST_MULT;
                end else if (start_div) begin
                    state_nxt = (data_operandB == '0) ? ST_ZERO : ST_DIV;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_ZERO: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ST_IDLE;
            acc            <= '0;
            opnd           <= '0;
            count          <= '0;
            neg            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_mult) begin
                acc   <= {{WIDTH{1'b0}}, b_mag};
                opnd  <= a_mag;
                neg   <= a_neg ^ b_neg;
                count <= '0;
            end else if (start_div) begin
                acc   <= {{WIDTH{1'b0}}, a_mag};
                opnd  <= b_mag;
                neg   <= a_neg ^ b_neg;
                count <= '0;
            end
            case (state)
                ST_MULT: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        data_result    <= prod_s[WIDTH-1:0];
                        data_exception <= mult_ovf ? MULT_OVF_EXC : 1'b0;
                    end
                end
                ST_DIV: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        data_result    <= quot_s;
                        data_exception <= div_ovf ? DIV_OVF_EXC : 1'b0;
                    end
                end
                ST_ZERO: begin
                    data_result    <= '0;
                    data_exception <= DIV0_EXC;
                end
                default: ;
            endcase
        end
    end

endmodule
